uart_param: RTL and testbench

Parametrised full-duplex UART: internal baud-tick generator, 16x-oversampled receiver and matching transmitter, each buffered by its own configurable FIFO.
Adds asynchronous active-low reset, error detection (framing, overrun, optional parity) and FIFO status flags.
Sits between the top-level serial pins and the host-side byte interface. Replaces the fixed-width UART.

---
 rtl/uart_param.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// Full-duplex 16x-oversampled UART with RX/TX FIFOs; optional even parity via UART_PARITY_EN.
// RX word visible 2 clk after stop mid-sample; host writes beyond tx_full and RX words beyond rx_full are dropped.
module uart_param_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] wdat_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, wnext, rnext;
  logic          empty_q, full_q, wr_en, rd_en;

  assign wnext  = wptr_q + AW'(1);
  assign rnext  = rptr_q + AW'(1);
  // A read frees a slot in the same cycle, so a full FIFO may still accept a write alongside it.
  assign wr_en  = wr_i & (~full_q | rd_i);
  assign rd_en  = rd_i & ~empty_q;
  assign rdat_o = mem_q[rptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wptr_q] <= wdat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wnext;
      if (rd_en) rptr_q <= rnext;
      if (wr_en && !rd_en) begin
        empty_q <= 1'b0;
        full_q  <= (wnext == rptr_q);
      end else if (rd_en && !wr_en) begin
        full_q  <= 1'b0;
        empty_q <= (rnext == wptr_q);
      end
    end
  end
endmodule

module uart_param #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            tx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  input  logic            err_clr,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            frame_err,
  output logic            overrun_err
`ifdef UART_PARITY_EN
  ,
  output logic            parity_err
`endif
);
  localparam int BW = $clog2(DVSR);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  logic [BW-1:0] baud_q, baud_d;
  logic          tick;

  assign tick   = (baud_q == BW'(DVSR - 1));
  assign baud_d = tick ? '0 : baud_q + BW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_q <= '0;
    else        baud_q <= baud_d;
  end

  logic [1:0] sync_q;
  logic       rx_s;
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // ---------------- receiver ----------------
  state_e          rx_st_q, rx_st_d;
  logic [SW-1:0]   rs_q, rs_d;
  logic [NW-1:0]   rn_q, rn_d;
  logic [DBIT-1:0] rb_q, rb_d;
  logic            rx_done, ferr_set, perr_set;

  always_comb begin
    rx_st_d  = rx_st_q;
    rs_d     = rs_q;
    rn_d     = rn_q;
    rb_d     = rb_q;
    rx_done  = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (rx_st_q)
      ST_IDLE: if (!rx_s) begin
        rx_st_d = ST_START;
        rs_d    = '0;
      end
      ST_START: if (tick) begin
        if (rs_q == SW'(7)) begin
          rs_d    = '0;
          rn_d    = '0;
          rx_st_d = rx_s ? ST_IDLE : ST_DATA;
        end else rs_d = rs_q + SW'(1);
      end
      ST_DATA: if (tick) begin
        if (rs_q == SW'(15)) begin
          rs_d = '0;
          rb_d = {rx_s, rb_q[DBIT-1:1]};
          if (rn_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
            rx_st_d = ST_PAR;
`else
            rx_st_d = ST_STOP;
`endif
          end else rn_d = rn_q + NW'(1);
        end else rs_d = rs_q + SW'(1);
      end
`ifdef UART_PARITY_EN
      ST_PAR: if (tick) begin
        if (rs_q == SW'(15)) begin
          rs_d     = '0;
          perr_set = rx_s ^ (^rb_q);
          rx_st_d  = ST_STOP;
        end else rs_d = rs_q + SW'(1);
      end
`endif
      ST_STOP: if (tick) begin
        // The state is entered mid last bit, so count 15 lands in the middle of the stop bit.
        if (rs_q == SW'(15) && !rx_s) ferr_set = 1'b1;
        if (rs_q == SW'(SB_TICK - 1)) begin
          rx_st_d = ST_IDLE;
          rx_done = 1'b1;
        end else rs_d = rs_q + SW'(1);
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= ST_IDLE;
      rs_q    <= '0;
      rn_q    <= '0;
      rb_q    <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      rs_q    <= rs_d;
      rn_q    <= rn_d;
      rb_q    <= rb_d;
    end
  end

  logic rx_push;
  assign rx_push = rx_done & ~rx_full;

  uart_param_fifo #(.W(DBIT), .AW(ADDR_W)) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (rx_push),
    .rd_i   (rd_uart),
    .wdat_i (rb_q),
    .rdat_o (r_data),
    .empty_o(rx_empty),
    .full_o (rx_full)
  );

  logic ferr_q, ferr_d, ovr_q, ovr_d;
  assign ferr_d = ferr_set ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
  assign ovr_d  = (rx_done & rx_full) ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

`ifdef UART_PARITY_EN
  logic perr_q, perr_d;
  assign perr_d     = perr_set ? 1'b1 : (err_clr ? 1'b0 : perr_q);
  assign parity_err = perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
`endif

  // ---------------- transmitter ----------------
  state_e          tx_st_q, tx_st_d;
  logic [SW-1:0]   ts_q, ts_d;
  logic [NW-1:0]   tn_q, tn_d;
  logic [DBIT-1:0] tb_q, tb_d, tx_head;
  logic            tx_q, tx_d, tx_pop;
`ifdef UART_PARITY_EN
  logic            tp_q, tp_d;
`endif

  // Frames start only on a tick so every bit, including start, is exactly 16 ticks long.
  always_comb begin
    tx_st_d = tx_st_q;
    ts_d    = ts_q;
    tn_d    = tn_q;
    tb_d    = tb_q;
    tx_d    = 1'b1;
    tx_pop  = 1'b0;
`ifdef UART_PARITY_EN
    tp_d    = tp_q;
`endif
    case (tx_st_q)
      ST_IDLE: if (tick && !tx_empty) begin
        tx_pop  = 1'b1;
        tb_d    = tx_head;
        ts_d    = '0;
        tx_st_d = ST_START;
`ifdef UART_PARITY_EN
        tp_d    = ^tx_head;
`endif
      end
      ST_START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (ts_q == SW'(15)) begin
            ts_d    = '0;
            tn_d    = '0;
            tx_st_d = ST_DATA;
          end else ts_d = ts_q + SW'(1);
        end
      end
      ST_DATA: begin
        tx_d = tb_q[0];
        if (tick) begin
          if (ts_q == SW'(15)) begin
            ts_d = '0;
            tb_d = tb_q >> 1;
            if (tn_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
              tx_st_d = ST_PAR;
`else
              tx_st_d = ST_STOP;
`endif
            end else tn_d = tn_q + NW'(1);
          end else ts_d = ts_q + SW'(1);
        end
      end
`ifdef UART_PARITY_EN
      ST_PAR: begin
        tx_d = tp_q;
        if (tick) begin
          if (ts_q == SW'(15)) begin
            ts_d    = '0;
            tx_st_d = ST_STOP;
          end else ts_d = ts_q + SW'(1);
        end
      end
`endif
      ST_STOP: if (tick) begin
        if (ts_q == SW'(SB_TICK - 1)) begin
          ts_d = '0;
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tb_d    = tx_head;
            tx_st_d = ST_START;
`ifdef UART_PARITY_EN
            tp_d    = ^tx_head;
`endif
          end else tx_st_d = ST_IDLE;
        end else ts_d = ts_q + SW'(1);
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= ST_IDLE;
      ts_q    <= '0;
      tn_q    <= '0;
      tb_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;
      ts_q    <= ts_d;
      tn_q    <= tn_d;
      tb_q    <= tb_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tp_q <= 1'b0;
    else        tp_q <= tp_d;
  end
`endif

  assign tx = tx_q;

  uart_param_fifo #(.W(DBIT), .AW(ADDR_W)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (wr_uart),
    .rd_i   (tx_pop),
    .wdat_i (w_data),
    .rdat_o (tx_head),
    .empty_o(tx_empty),
    .full_o (tx_full)
  );
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at DVSR=2, DBIT=8, ADDR_W=2 (one bit = 32 clk).
module tb_uart_param;
  localparam int DBIT = 8;
  localparam int DV   = 2;
  localparam int AW   = 2;
  localparam int BIT  = 16 * DV;

  logic            clk, rst_n, rx_drv, loop_en, rx_line, tx;
  logic            rd_uart, wr_uart, err_clr;
  logic [DBIT-1:0] r_data, w_data;
  logic            rx_empty, rx_full, tx_full, tx_empty, frame_err, overrun_err;

  int n_tests = 0;
  int n_fail  = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_param #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DV), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx),
    .rd_uart(rd_uart), .r_data(r_data), .wr_uart(wr_uart), .w_data(w_data),
    .err_clr(err_clr), .rx_empty(rx_empty), .rx_full(rx_full),
    .tx_full(tx_full), .tx_empty(tx_empty),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       stop_ok;
    logic [7:0] exp_dat;
    logic       exp_ferr;
  } rxv_t;

  rxv_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd_uart = 1'b1;
    wait_cyc(1);
    rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(1);
  endtask

  task automatic write_word(input logic [7:0] d);
    w_data  = d;
    wr_uart = 1'b1;
    wait_cyc(1);
    wr_uart = 1'b0;
  endtask

  // Short stop bit when stop_ok=0 keeps the trailing low from looking like a new start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    rx_drv = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      wait_cyc(BIT);
    end
    rx_drv = stop_ok;
    if (stop_ok) wait_cyc(BIT);
    else begin
      wait_cyc(24);
      rx_drv = 1'b1;
      wait_cyc(8);
    end
    rx_drv = 1'b1;
    wait_cyc(2 * BIT);
  endtask

  task automatic wait_tx_fall(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (tx == 1'b0) seen = 1'b1;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] lb [3];
    logic [7:0] ov [5];
    int lows;

    vecs[0] = '{8'h55, 1'b0, 8'h55, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    a5 = 8'hA5;
    lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h00;
    ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;

    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    rd_uart = 1'b0; wr_uart = 1'b0; err_clr = 1'b0; w_data = '0;
    wait_cyc(3);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_rx_empty", {31'b0, rx_empty}, 32'd1);
    check("rst_tx_empty", {31'b0, tx_empty}, 32'd1);
    check("rst_rx_full", {31'b0, rx_full}, 32'd0);
    check("rst_tx_full", {31'b0, tx_full}, 32'd0);
    check("rst_r_data", {24'b0, r_data}, 32'd0);
    check("rst_errs", {30'b0, frame_err, overrun_err}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // TX waveform for 0xA5
    write_word(a5);
    check("tx_fifo_loaded", {31'b0, tx_empty}, 32'd0);
    wait_tx_fall("tx_a5_start_seen");
    wait_cyc(16);
    check("tx_start_mid", {31'b0, tx}, 32'd0);
    check("tx_empty_after_pop", {31'b0, tx_empty}, 32'd1);
    wait_cyc(15);
    check("tx_start_end", {31'b0, tx}, 32'd0);
    wait_cyc(1);
    check("tx_bit0_edge", {31'b0, tx}, {31'b0, a5[0]});
    wait_cyc(16);
    for (int k = 1; k < 8; k++) begin
      wait_cyc(BIT);
      check($sformatf("tx_bit%0d", k), {31'b0, tx}, {31'b0, a5[k]});
    end
    wait_cyc(BIT);
    check("tx_stop", {31'b0, tx}, 32'd1);
    wait_cyc(BIT);
    check("tx_idle_after", {31'b0, tx}, 32'd1);

    // Table-driven receive vectors
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].din, vecs[v].stop_ok);
      check($sformatf("vec%0d_r_data", v), {24'b0, r_data}, {24'b0, vecs[v].exp_dat});
      check($sformatf("vec%0d_rx_empty", v), {31'b0, rx_empty}, 32'd0);
      check($sformatf("vec%0d_frame_err", v), {31'b0, frame_err}, {31'b0, vecs[v].exp_ferr});
      pulse_rd();
      wait_cyc(1);
      check($sformatf("vec%0d_empty_after_rd", v), {31'b0, rx_empty}, 32'd1);
      pulse_clr();
      check($sformatf("vec%0d_err_cleared", v), {31'b0, frame_err}, 32'd0);
    end

    // Start glitch of 5 ticks
    rx_drv = 1'b0;
    wait_cyc(5 * DV);
    rx_drv = 1'b1;
    wait_cyc(20 * BIT);
    check("glitch_rx_empty", {31'b0, rx_empty}, 32'd1);
    check("glitch_frame_err", {31'b0, frame_err}, 32'd0);

    // Loopback, three back-to-back words
    loop_en = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 3; i++) write_word(lb[i]);
    wait_cyc(40 * BIT);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lb%0d_nonempty", i), {31'b0, rx_empty}, 32'd0);
      check($sformatf("lb%0d_data", i), {24'b0, r_data}, {24'b0, lb[i]});
      pulse_rd();
      wait_cyc(1);
    end
    check("lb_empty_after", {31'b0, rx_empty}, 32'd1);
    check("lb_errs", {30'b0, frame_err, overrun_err}, 32'd0);
    check("lb_tx_empty", {31'b0, tx_empty}, 32'd1);
    loop_en = 1'b0;
    wait_cyc(BIT);

    // Overrun with a 4-deep RX FIFO
    for (int i = 0; i < 4; i++) send_frame(ov[i], 1'b1);
    check("ovr_full_after4", {31'b0, rx_full}, 32'd1);
    check("ovr_flag_after4", {31'b0, overrun_err}, 32'd0);
    send_frame(ov[4], 1'b1);
    check("ovr_flag_after5", {31'b0, overrun_err}, 32'd1);
    check("ovr_full_after5", {31'b0, rx_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_rd%0d", i), {24'b0, r_data}, {24'b0, ov[i]});
      pulse_rd();
      wait_cyc(1);
    end
    check("ovr_empty_after", {31'b0, rx_empty}, 32'd1);
    pulse_clr();
    check("ovr_cleared", {31'b0, overrun_err}, 32'd0);

    // Reset in the middle of a data bit
    write_word(8'h81);
    wait_tx_fall("rst_tx_start_seen");
    wait_cyc(BIT + BIT + 16);
    check("rst_pre_tx_low", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_high", {31'b0, tx}, 32'd1);
    check("rst_mid_tx_empty", {31'b0, tx_empty}, 32'd1);
    wait_cyc(2);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20 * BIT; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("rst_no_residual", lows, 32'd0);
    check("rst_rx_empty_after", {31'b0, rx_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
